// File: rtl/rob_multi_commit.sv
// Reorder buffer with dual-slot in-order dispatch, NUM_EX out-of-order completion
// ports and up to two in-order retirements per cycle into the architectural file.
module rob_multi_commit #(
  parameter int DEPTH  = 64,
  parameter int NUM_EX = 4,
  parameter int REG_W  = 5,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dp1_i,
  input  logic                    dp2_i,
  input  logic [REG_W-1:0]        dst_dp1_i,
  input  logic [REG_W-1:0]        dst_dp2_i,
  input  logic                    isValid_dst_dp1_i,
  input  logic                    isValid_dst_dp2_i,
  input  logic [NUM_EX-1:0]       finish_ex_i,
  input  logic [NUM_EX*PTR_W-1:0] ex_addr_i,
  input  logic                    flush_i,
  output logic [PTR_W-1:0]        dp_ptr_o,
  output logic                    allow_dispatch_o,
  output logic [PTR_W-1:0]        commit_ptr_o,
  output logic                    arfwe_1_o,
  output logic                    arfwe_2_o,
  output logic [REG_W-1:0]        dst_arf_1_o,
  output logic [REG_W-1:0]        dst_arf_2_o,
  output logic [1:0]              comnum_o,
  output logic [PTR_W:0]          count_o
);

  localparam logic [PTR_W:0] LP_DP_LIMIT = (PTR_W+1)'(DEPTH - 2);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_finished;
  logic [DEPTH-1:0] r_dst_valid;
  logic [REG_W-1:0] r_dst [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  logic             w_allow;
  logic             w_acc1;
  logic             w_acc2;
  logic [1:0]       w_num_acc;
  logic             w_ret1;
  logic             w_ret2;
  logic [1:0]       w_comnum;
  logic [PTR_W-1:0] w_head_nxt;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [DEPTH-1:0] w_fin_nxt;

  // Dispatch handshake: a slot transfers on a clock edge when its request is high
  // and allow_dispatch_o (ready) is high; slot 2 only rides along with slot 1.
  assign w_head1   = r_head + PTR_W'(1);
  assign w_tail1   = r_tail + PTR_W'(1);
  assign w_allow   = (r_count <= LP_DP_LIMIT);
  assign w_acc1    = w_allow & dp1_i;
  assign w_acc2    = w_acc1 & dp2_i;
  assign w_num_acc = {w_acc2, w_acc1 & ~w_acc2};

  assign w_ret1     = r_valid[r_head] & r_finished[r_head];
  assign w_ret2     = w_ret1 & r_valid[w_head1] & r_finished[w_head1];
  assign w_comnum   = {w_ret2, w_ret1 & ~w_ret2};
  assign w_head_nxt = r_head + PTR_W'(w_comnum);

  // Order matters: completions first, then retirement clears, then new allocations.
  always_comb begin
    w_valid_nxt = r_valid;
    w_fin_nxt   = r_finished;
    for (int k = 0; k < NUM_EX; k++) begin
      if (finish_ex_i[k] && r_valid[ex_addr_i[k*PTR_W +: PTR_W]])
        w_fin_nxt[ex_addr_i[k*PTR_W +: PTR_W]] = 1'b1;
    end
    if (w_ret1) begin
      w_valid_nxt[r_head] = 1'b0;
      w_fin_nxt[r_head]   = 1'b0;
    end
    if (w_ret2) begin
      w_valid_nxt[w_head1] = 1'b0;
      w_fin_nxt[w_head1]   = 1'b0;
    end
    if (w_acc1) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_fin_nxt[r_tail]   = 1'b0;
    end
    if (w_acc2) begin
      w_valid_nxt[w_tail1] = 1'b1;
      w_fin_nxt[w_tail1]   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_finished  <= '0;
      r_dst_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_dst[i] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (flush_i) begin
        // Retirements this cycle still land; everything younger is dropped.
        r_valid    <= '0;
        r_finished <= '0;
        r_tail     <= w_head_nxt;
        r_count    <= '0;
      end else begin
        r_valid    <= w_valid_nxt;
        r_finished <= w_fin_nxt;
        r_tail     <= r_tail + PTR_W'(w_num_acc);
        r_count    <= r_count + (PTR_W+1)'(w_num_acc) - (PTR_W+1)'(w_comnum);
        if (w_acc1) begin
          r_dst[r_tail]       <= dst_dp1_i;
          r_dst_valid[r_tail] <= isValid_dst_dp1_i;
        end
        if (w_acc2) begin
          r_dst[w_tail1]       <= dst_dp2_i;
          r_dst_valid[w_tail1] <= isValid_dst_dp2_i;
        end
      end
    end
  end

  assign dp_ptr_o         = r_tail;
  assign commit_ptr_o     = r_head;
  assign count_o          = r_count;
  assign allow_dispatch_o = w_allow;
  assign comnum_o         = w_comnum;
  assign arfwe_1_o        = w_ret1 & r_dst_valid[r_head];
  assign arfwe_2_o        = w_ret2 & r_dst_valid[w_head1];
  assign dst_arf_1_o      = w_ret1 ? r_dst[r_head]  : '0;
  assign dst_arf_2_o      = w_ret2 ? r_dst[w_head1] : '0;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit at DEPTH=8: single/dual retire, ordering,
// full-threshold, flush, mid-run reset and a pointer-wrapping stream.
module tb_rob_multi_commit;

  localparam int DEPTH  = 8;
  localparam int NUM_EX = 4;
  localparam int REG_W  = 5;
  localparam int PTR_W  = 3;

  logic                    clk;
  logic                    reset;
  logic                    dp1, dp2;
  logic [REG_W-1:0]        dst1, dst2;
  logic                    v1, v2;
  logic [NUM_EX-1:0]       fin_ex;
  logic [NUM_EX*PTR_W-1:0] ex_addr;
  logic                    flush;
  logic [PTR_W-1:0]        dp_ptr, commit_ptr;
  logic                    allow, arfwe1, arfwe2;
  logic [REG_W-1:0]        arf1, arf2;
  logic [1:0]              comnum;
  logic [PTR_W:0]          count;

  int checks = 0;
  int errors = 0;
  int tb_tail, tb_head, d;
  logic [REG_W-1:0] exp_q[$];
  logic [REG_W-1:0] exp_dst;

  rob_multi_commit #(.DEPTH(DEPTH), .NUM_EX(NUM_EX), .REG_W(REG_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .dp1_i(dp1), .dp2_i(dp2),
    .dst_dp1_i(dst1), .dst_dp2_i(dst2),
    .isValid_dst_dp1_i(v1), .isValid_dst_dp2_i(v2),
    .finish_ex_i(fin_ex), .ex_addr_i(ex_addr), .flush_i(flush),
    .dp_ptr_o(dp_ptr), .allow_dispatch_o(allow), .commit_ptr_o(commit_ptr),
    .arfwe_1_o(arfwe1), .arfwe_2_o(arfwe2),
    .dst_arf_1_o(arf1), .dst_arf_2_o(arf2),
    .comnum_o(comnum), .count_o(count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    dp1 = 0; dp2 = 0; dst1 = '0; dst2 = '0; v1 = 0; v2 = 0;
    fin_ex = '0; ex_addr = '0; flush = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic fin(input int k, input int addr);
    fin_ex[k] = 1'b1;
    ex_addr[k*PTR_W +: PTR_W] = PTR_W'(addr);
  endtask

  task automatic disp(input logic two, input int da, input logic va, input int db, input logic vb);
    dp1 = 1; dst1 = REG_W'(da); v1 = va;
    dp2 = two; dst2 = REG_W'(db); v2 = vb;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;

    // Reset state
    check("rst_commit_ptr", 32'(commit_ptr), 0);
    check("rst_dp_ptr", 32'(dp_ptr), 0);
    check("rst_count", 32'(count), 0);
    check("rst_allow", 32'(allow), 1);
    check("rst_arfwe1", 32'(arfwe1), 0);
    check("rst_arfwe2", 32'(arfwe2), 0);
    check("rst_comnum", 32'(comnum), 0);
    check("rst_arf1", 32'(arf1), 0);

    // Single dispatch, finish, retire
    disp(0, 5, 1, 0, 0); cyc();
    check("s_count", 32'(count), 1);
    check("s_dp_ptr", 32'(dp_ptr), 1);
    check("s_nocommit", 32'(comnum), 0);
    fin(0, 0); cyc();
    check("s_arfwe1", 32'(arfwe1), 1);
    check("s_arf1", 32'(arf1), 5);
    check("s_comnum", 32'(comnum), 1);
    check("s_arfwe2", 32'(arfwe2), 0);
    cyc();
    check("s_head", 32'(commit_ptr), 1);
    check("s_count0", 32'(count), 0);

    // Dual dispatch, both finish together, dual retire
    disp(1, 6, 1, 7, 1); cyc();
    check("d_dp_ptr", 32'(dp_ptr), 3);
    check("d_count", 32'(count), 2);
    fin(0, 1); fin(1, 2); cyc();
    check("d_arfwe1", 32'(arfwe1), 1);
    check("d_arfwe2", 32'(arfwe2), 1);
    check("d_arf1", 32'(arf1), 6);
    check("d_arf2", 32'(arf2), 7);
    check("d_comnum", 32'(comnum), 2);
    cyc();
    check("d_head", 32'(commit_ptr), 3);
    check("d_count0", 32'(count), 0);

    // Out-of-order completion waits for the head
    disp(1, 8, 1, 9, 1); cyc();
    fin(2, 4); cyc();
    check("o_blocked", 32'(comnum), 0);
    check("o_blocked_we", 32'(arfwe1), 0);
    cyc();
    check("o_still_blocked", 32'(comnum), 0);
    fin(3, 3); cyc();
    check("o_comnum", 32'(comnum), 2);
    check("o_arf1", 32'(arf1), 8);
    check("o_arf2", 32'(arf2), 9);
    cyc();
    check("o_head", 32'(commit_ptr), 5);

    // Entry without a destination retires without an ARF write
    disp(0, 12, 0, 0, 0); cyc();
    fin(1, 5); cyc();
    check("n_comnum", 32'(comnum), 1);
    check("n_arfwe1", 32'(arfwe1), 0);
    check("n_arf1", 32'(arf1), 12);
    cyc();

    // Finish on an empty entry is ignored; duplicate ports are legal
    fin(0, 7); cyc();
    disp(1, 1, 1, 2, 1); cyc();
    fin(0, 6); cyc();
    check("i_comnum", 32'(comnum), 1);
    check("i_arf1", 32'(arf1), 1);
    check("i_arfwe2", 32'(arfwe2), 0);
    cyc();
    check("i_head", 32'(commit_ptr), 7);
    check("i_count", 32'(count), 1);
    fin(0, 7); fin(1, 7); cyc();
    check("dup_comnum", 32'(comnum), 1);
    check("dup_arf1", 32'(arf1), 2);
    cyc();
    check("wrap_head", 32'(commit_ptr), 0);
    check("wrap_tail", 32'(dp_ptr), 0);

    // dp2 without dp1 is ignored
    dp2 = 1; dst2 = 5'd3; v2 = 1; cyc();
    check("dp2only_count", 32'(count), 0);
    check("dp2only_ptr", 32'(dp_ptr), 0);

    // Fill to DEPTH-1
    disp(1, 10, 1, 11, 1); cyc();
    disp(1, 12, 1, 13, 1); cyc();
    disp(1, 14, 1, 15, 1); cyc();
    check("f_count6", 32'(count), 6);
    check("f_allow6", 32'(allow), 1);
    disp(0, 16, 1, 0, 0); cyc();
    check("f_count7", 32'(count), 7);
    check("f_allow7", 32'(allow), 0);
    disp(1, 30, 1, 31, 1); cyc();
    check("f_ignored_count", 32'(count), 7);
    check("f_ignored_ptr", 32'(dp_ptr), 7);
    fin(0, 0); cyc();
    check("f_arf1", 32'(arf1), 10);
    cyc();
    check("f_count_after", 32'(count), 6);
    check("f_allow_after", 32'(allow), 1);
    fin(0, 1); cyc();
    check("f_arf1_b", 32'(arf1), 11);
    cyc();
    check("f_count5", 32'(count), 5);

    // Flush with a retiring head
    fin(0, 2); cyc();
    check("fl_comnum", 32'(comnum), 1);
    check("fl_arf1", 32'(arf1), 12);
    flush = 1; disp(0, 25, 1, 0, 0); fin(1, 3); cyc();
    check("fl_count", 32'(count), 0);
    check("fl_head", 32'(commit_ptr), 3);
    check("fl_tail", 32'(dp_ptr), 3);
    check("fl_comnum0", 32'(comnum), 0);
    check("fl_allow", 32'(allow), 1);
    disp(0, 20, 1, 0, 0); cyc();
    check("fl_redisp_count", 32'(count), 1);
    check("fl_not_finished", 32'(comnum), 0);
    fin(0, 3); cyc();
    check("fl_arf1", 32'(arf1), 20);
    cyc();
    check("fl_head2", 32'(commit_ptr), 4);

    // Asynchronous reset mid-operation
    disp(1, 3, 1, 4, 1); fin(0, 4); cyc();
    #2 reset = 1;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_head", 32'(commit_ptr), 0);
    check("ar_tail", 32'(dp_ptr), 0);
    check("ar_allow", 32'(allow), 1);
    check("ar_comnum", 32'(comnum), 0);
    @(negedge clk);
    reset = 0;

    // Streaming dispatch/commit across 3*DEPTH entries (scoreboard)
    tb_tail = 0;
    tb_head = 0;
    for (int n = 0; n < 3*DEPTH; n++) begin
      d = $urandom_range(0, 31);
      disp(0, d, 1, 0, 0);
      exp_q.push_back(REG_W'(d));
      if (n > 0) fin(0, (tb_tail + DEPTH - 1) % DEPTH);
      tb_tail = (tb_tail + 1) % DEPTH;
      cyc();
      if (n >= 2) tb_head = (tb_head + 1) % DEPTH;
      check("st_count", 32'(count), (n == 0) ? 1 : 2);
      check("st_tail", 32'(dp_ptr), 32'(tb_tail));
      check("st_head", 32'(commit_ptr), 32'(tb_head));
      if (n >= 1) begin
        exp_dst = exp_q.pop_front();
        check("st_comnum", 32'(comnum), 1);
        check("st_arfwe1", 32'(arfwe1), 1);
        check("st_arf1", 32'(arf1), 32'(exp_dst));
      end else begin
        check("st_comnum0", 32'(comnum), 0);
      end
    end
    fin(0, (tb_tail + DEPTH - 1) % DEPTH); cyc();
    exp_dst = exp_q.pop_front();
    check("st_drain_comnum", 32'(comnum), 1);
    check("st_drain_arf1", 32'(arf1), 32'(exp_dst));
    cyc();
    check("st_final_count", 32'(count), 0);
    check("st_final_head", 32'(commit_ptr), 32'(tb_tail));
    check("st_queue_empty", 32'(exp_q.size()), 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
